// File: rtl/cntdn_bb4.sv
// Cascadable 4-bit synchronous down counter with combinational borrow-out and registered terminal-count pulse.
// Optional feature: define CNTDN_BB4_RELOAD_EN to reload from the last parallel-load value instead of wrapping to 1111.
module cntdn_bb4 (
  input  logic CLK,
  input  logic CDN,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic BI,
  input  logic EN,
  input  logic LD,
  input  logic CS,
  input  logic SS,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic BO,
  output logic TC
);

  logic [3:0] count_q, count_d;
  logic [3:0] d_in;
  logic [3:0] wrap_val;
  logic       tc_q, tc_d;
  logic       dec;
  logic       ld_take;

  assign d_in    = {D3, D2, D1, D0};
  assign dec     = BI & EN;
  assign ld_take = LD & ~CS & ~SS;

`ifdef CNTDN_BB4_RELOAD_EN
  logic [3:0] reload_q, reload_d;

  always_comb begin
    reload_d = reload_q;
    if (ld_take) reload_d = d_in;
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) reload_q <= 4'h0;
    else      reload_q <= reload_d;
  end

  assign wrap_val = reload_q;
`else
  assign wrap_val = 4'hF;
`endif

  // Priority: clear, set, load, decrement, hold. TC marks a decrement out of 0000.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (CS) begin
      count_d = 4'h0;
    end else if (SS) begin
      count_d = 4'hF;
    end else if (ld_take) begin
      count_d = d_in;
    end else if (dec) begin
      if (count_q == 4'h0) begin
        count_d = wrap_val;
        tc_d    = 1'b1;
      end else begin
        count_d = count_q - 4'h1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      count_q <= 4'h0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  // Borrow-out is combinational so a chain of stages decrements in one cycle.
  assign BO = dec & (count_q == 4'h0);
  assign TC = tc_q;
  assign {Q3, Q2, Q1, Q0} = count_q;

endmodule

// File: tb/tb_cntdn_bb4.sv
// Bench for cntdn_bb4: two stages cascaded as an 8-bit down counter, checked against an arithmetic model.
// Honours CNTDN_BB4_RELOAD_EN for the expected wrap value.
module tb_cntdn_bb4;

  logic       clk;
  logic       cdn;
  logic       bi, en, ld, cs, ss;
  logic [7:0] d;
  logic [3:0] q_lo, q_hi;
  logic       bo_lo, bo_hi, tc_lo, tc_hi;

  int total = 0;
  int bad   = 0;

  // expected entry: {q[7:0], tc_hi, tc_lo, bo_hi, bo_lo}
  logic [11:0] exp_q[$];

  // reference model state
  logic [7:0] m_v;
  logic       m_tc_lo, m_tc_hi;
`ifdef CNTDN_BB4_RELOAD_EN
  logic [7:0] m_rl;
`endif

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cntdn_bb4 u_lo (
    .CLK(clk), .CDN(cdn),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .BI(bi), .EN(en), .LD(ld), .CS(cs), .SS(ss),
    .Q0(q_lo[0]), .Q1(q_lo[1]), .Q2(q_lo[2]), .Q3(q_lo[3]),
    .BO(bo_lo), .TC(tc_lo)
  );

  cntdn_bb4 u_hi (
    .CLK(clk), .CDN(cdn),
    .D0(d[4]), .D1(d[5]), .D2(d[6]), .D3(d[7]),
    .BI(bo_lo), .EN(en), .LD(ld), .CS(cs), .SS(ss),
    .Q0(q_hi[0]), .Q1(q_hi[1]), .Q2(q_hi[2]), .Q3(q_hi[3]),
    .BO(bo_hi), .TC(tc_hi)
  );

  // One clock edge of the 8-bit counter, computed from the value rules.
  task automatic model_edge(input bit b, input bit e, input bit l, input bit c,
                            input bit s, input logic [7:0] dv);
    logic [3:0] lo, hi;
    m_tc_lo = 1'b0;
    m_tc_hi = 1'b0;
    if (c) m_v = 8'h00;
    else if (s) m_v = 8'hFF;
    else if (l) begin
      m_v = dv;
`ifdef CNTDN_BB4_RELOAD_EN
      m_rl = dv;
`endif
    end else if (b && e) begin
      lo = m_v[3:0];
      hi = m_v[7:4];
      m_tc_lo = (lo == 4'h0);
      m_tc_hi = (m_v == 8'h00);
`ifdef CNTDN_BB4_RELOAD_EN
      if (lo != 4'h0) lo = lo - 4'h1;
      else begin
        lo = m_rl[3:0];
        if (hi == 4'h0) hi = m_rl[7:4];
        else hi = hi - 4'h1;
      end
      m_v = {hi, lo};
`else
      m_v = m_v - 8'd1;
`endif
    end
  endtask

  // driver: apply one cycle of inputs just after the rising edge
  task automatic drive(input bit c_n, input bit b, input bit e, input bit l,
                       input bit c, input bit s, input logic [7:0] dv);
    logic exp_bo_lo, exp_bo_hi;
    @(posedge clk);
    #1;
    cdn = c_n; bi = b; en = e; ld = l; cs = c; ss = s; d = dv;
    if (!c_n) begin
      m_v = 8'h00;
      m_tc_lo = 1'b0;
      m_tc_hi = 1'b0;
`ifdef CNTDN_BB4_RELOAD_EN
      m_rl = 8'h00;
`endif
    end
    exp_bo_lo = b & e & (m_v[3:0] == 4'h0);
    exp_bo_hi = b & e & (m_v == 8'h00);
    exp_q.push_back({m_v, m_tc_hi, m_tc_lo, exp_bo_hi, exp_bo_lo});
    if (c_n) model_edge(b, e, l, c, s, dv);
  endtask

  task automatic count(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 1, 0, 0, 0, 8'h00);
  endtask

  // scoreboard monitor: mid-cycle, compare outputs with the oldest expectation
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({q_hi, q_lo} !== e[11:4]) begin
        bad++;
        $display("FAIL count: got %h want %h at %0t", {q_hi, q_lo}, e[11:4], $time);
      end
      total++;
      if ({tc_hi, tc_lo} !== e[3:2]) begin
        bad++;
        $display("FAIL tc(hi,lo): got %b want %b at %0t", {tc_hi, tc_lo}, e[3:2], $time);
      end
      total++;
      if ({bo_hi, bo_lo} !== e[1:0]) begin
        bad++;
        $display("FAIL bo(hi,lo): got %b want %b at %0t", {bo_hi, bo_lo}, e[1:0], $time);
      end
    end
  end

  initial begin
    cdn = 1'b0; bi = 1'b0; en = 1'b0; ld = 1'b0; cs = 1'b0; ss = 1'b0; d = 8'h00;
    m_v = 8'h00; m_tc_lo = 1'b0; m_tc_hi = 1'b0;
`ifdef CNTDN_BB4_RELOAD_EN
    m_rl = 8'h00;
`endif

    // reset, then free count from zero: wrap and one TC pulse
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 1, 1, 1, 1, 1, 8'h5A);
    drive(1, 1, 1, 0, 0, 0, 8'h00);
    count(3);

    // load 05 and count through zero
    drive(1, 1, 1, 1, 0, 0, 8'h05);
    count(8);

    // control priorities
    drive(1, 1, 1, 1, 1, 1, 8'hAA);
    drive(1, 1, 1, 1, 0, 1, 8'hAA);
    drive(1, 1, 1, 1, 0, 0, 8'hA6);
    drive(1, 1, 1, 1, 0, 0, 8'h3C);
    drive(1, 0, 0, 0, 0, 0, 8'h00);

    // cascade: 0x10 -> 0x0F in one edge
    drive(1, 1, 1, 1, 0, 0, 8'h10);
    count(3);

    // EN low at zero holds and blocks borrow; BI low also holds
    drive(1, 1, 1, 0, 1, 0, 8'h00);
    drive(1, 1, 0, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 1, 0, 0, 0, 8'h00);

    // async clear mid-count at 03, then with a wrap pending
    drive(1, 1, 1, 1, 0, 0, 8'h05);
    count(2);
    drive(0, 1, 1, 0, 0, 0, 8'h00);
    drive(1, 1, 1, 0, 0, 0, 8'h00);
    drive(1, 1, 1, 1, 0, 0, 8'h00);
    drive(0, 1, 1, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    count(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(49) != 0), ($urandom_range(7) != 0), ($urandom_range(3) != 0),
            ($urandom_range(7) == 0), ($urandom_range(15) == 0), ($urandom_range(15) == 0),
            8'($urandom_range(255)));
    end
    drive(1, 0, 0, 0, 0, 0, 8'h00);

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cntdn_bb4.md
CNTDN_BB4 -- requirements
Module: cntdn_bb4

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge except asynchronous clear.
REQ-002 The block SHALL have the port CDN, input, 1 bit: asynchronous active-low clear.
REQ-003 The block SHALL have the ports D0..D3, input, 1 bit each: parallel load data, D0 is the LSB.
REQ-004 The block SHALL have the port BI, input, 1 bit: borrow-in, active high, driven by BO of the lower cascade stage (tie high for the LSB stage).
REQ-005 The block SHALL have the port EN, input, 1 bit: count enable, active high.
REQ-006 The block SHALL have the port LD, input, 1 bit: synchronous parallel load, active high.
REQ-007 The block SHALL have the port CS, input, 1 bit: synchronous clear to 0000, active high.
REQ-008 The block SHALL have the port SS, input, 1 bit: synchronous set to 1111, active high.
REQ-009 The block SHALL have the ports Q0..Q3, output, 1 bit each: registered count, Q0 is the LSB.
REQ-010 The block SHALL have the port BO, output, 1 bit: combinational borrow-out, equal to BI & EN & (Q==0000).
REQ-011 The block SHALL have the port TC, output, 1 bit: registered terminal-count pulse.

Function
REQ-012 Per rising CLK edge, the count SHALL follow this priority, highest first: CS -> 0000; SS -> 1111; LD -> {D3,D2,D1,D0}; BI&EN -> count-1; otherwise hold.
REQ-013 Decrement SHALL be modulo 16: 0000 with BI&EN and no higher-priority control SHALL become 1111 (without CNTDN_BB4_RELOAD_EN).
REQ-014 BO SHALL have zero latency from BI, EN and Q, so N stages cascade as one 4N-bit down counter decrementing in a single cycle.
REQ-015 BO SHALL be asserted whenever BI&EN&(Q==0000), regardless of CS, SS and LD.
REQ-016 TC SHALL be 1 for exactly one cycle, the cycle after an edge at which decrement-from-0000 (wrap or reload) was taken, and 0 otherwise.
REQ-017 TC SHALL NOT assert when 0000 is reached via CS or LD, nor when the count is held at 0000.
REQ-018 With CS and SS both high, CS SHALL win; with LD and BI&EN both high, LD SHALL win and no decrement SHALL occur.
REQ-019 EN low SHALL hold the count and force BO to 0 irrespective of BI.

Reset
REQ-020 CDN low SHALL immediately force Q=0000 and TC=0, and clear the reload register to 0000 when CNTDN_BB4_RELOAD_EN is defined.
REQ-021 While CDN is low, all synchronous inputs SHALL be ignored; BO SHALL follow REQ-010 using Q=0000.
REQ-022 Operation SHALL resume at the first rising CLK edge after CDN deasserts; CDN assertion mid-count SHALL abandon any pending TC.

Configuration
REQ-023 With macro CNTDN_BB4_RELOAD_EN defined, a 4-bit reload register SHALL capture {D3..D0} on every edge where LD is taken per REQ-012.
REQ-024 With CNTDN_BB4_RELOAD_EN defined, decrement-from-0000 SHALL load the reload register instead of 1111; BO and TC SHALL behave as on a wrap.
REQ-025 With CNTDN_BB4_RELOAD_EN undefined, no reload register SHALL exist and behaviour SHALL be exactly REQ-013.

Verification
REQ-026 The bench SHALL cover: CDN=0 -> Q=0000, TC=0; release, then BI=EN=1 for 3 cycles -> Q=1111, 1110, 1101; TC pulses once, after the first edge.
REQ-027 The bench SHALL cover: LD=1, D=0101, then BI=EN=1 -> Q=0101, 0100, ..., 0000; BO=1 only while Q=0000; the next edge -> Q=1111 (reload off) or 0101 (reload on), with TC=1 for one cycle.
REQ-028 The bench SHALL cover: CS=SS=LD=1 with D=1010 -> Q=0000; SS=LD=1 -> Q=1111; LD=1 with BI=EN=1 -> Q=D, no decrement.
REQ-029 The bench SHALL cover: two stages cascaded (BI of the upper stage = BO of the lower), load 0x10, count enabled -> 0x0F after one edge; the upper stage decrements only on that edge.
REQ-030 The bench SHALL cover: EN=0, BI=1 at Q=0000 -> BO=0 and Q holds; CDN pulsed low mid-count at Q=0011 -> Q=0000 asynchronously and no TC.
